ofifo: RTL and testbench
========================

Name: ofifo

Overview:
- Output FIFO sitting directly downstream of the MAC row/array south edge.
- Consumes per-column partial sums (out_s) and per-column valid strobes, which arrive skewed in time across columns.
- Buffers each column independently and re-aligns the columns, so the consumer (SRAM write / SFU) pops one full aligned row of col psums at a time.

Parameters:
- col, 8, number of columns (one independent column queue each)
- psum_bw, 16, width of one partial sum
- depth, 64, entries per column queue; power of 2, at least 2

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- in  input  psum_bw*col  column psums; column i occupies bits [psum_bw*(i+1)-1 : psum_bw*i]
- wr  input  col  per-column write strobes (the MAC row valid bus)
- rd  input  1  pop one aligned row
- out  output  psum_bw*col  head entry of every column queue, same packing as in
- o_full  output  1  at least one column queue is full
- o_ready  output  1  every column queue can accept a write (equals ~o_full)
- o_valid  output  1  every column queue is non-empty

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset. While reset is high:
  - all pointers are cleared and all storage is cleared to 0;
  - out=0, o_full=0, o_ready=1, o_valid=0.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Column queue i pointers:
  - wr_ptr_i and rd_ptr_i are each log2(depth)+1 bits wide (the extra MSB is the wrap bit).
  - empty_i = (wr_ptr_i == rd_ptr_i).
  - full_i = (low bits equal AND MSBs differ).
- Write:
  - On a rising edge with wr[i]=1 and full_i=0, mem_i[wr_ptr_i] <= in column i and wr_ptr_i increments.
  - A write with full_i=1 is dropped; no pointer or storage changes.
- Read:
  - On a rising edge with rd=1 and o_valid=1, every rd_ptr_i increments, popping one entry from each column.
  - rd with o_valid=0 is ignored; no pointer moves.
- Output timing:
  - out is show-ahead (combinational from storage at rd_ptr_i); zero read latency.
  - out is meaningful only while o_valid=1.
  - After a column's queue has been emptied, its out slice holds the stale previously read value.
- Flags: o_full = OR(full_i); o_ready = ~o_full; o_valid = AND(~empty_i). All are combinational from pointers, with no extra registering.
- Write to an empty column: the entry becomes visible on the following cycle. There is no write-to-read bypass within a cycle.
- Simultaneous rd and wr[i] on the same edge: both take effect.
  - fullness is evaluated on pre-edge state, so a write to a column that is full at the edge is dropped even if rd pops that column on the same edge;
  - count_i is unchanged when both take effect.
- Wrap-around: pointers wrap naturally modulo 2*depth; storage is indexed by the low log2(depth) bits.
- Skew handling: columns fill at different times. o_valid rises only when the last (most-lagging) column has its first entry.
- Order: within a column, strictly first-in first-out.

Optional Feature:
- Macro: OFIFO_OVERFLOW_FLAG_EN
- Defined:
  - adds output port o_overflow (1 bit);
  - o_overflow is a sticky flag set on any clock edge where wr[i]=1 and full_i=1 for any i;
  - it is cleared only by reset and resets to 0.
- Not defined: the port does not exist and overflow writes are silently dropped.

Test Plan:
- Reset, then no activity -> out=0, o_valid=0, o_full=0, o_ready=1; asserting reset mid-fill clears o_valid asynchronously, before any clock edge.
- Staircase skew, col=8: column i writes value 100+i starting at cycle i -> o_valid stays 0 until cycle 8, then rises; out = {107,...,100}.
- Aligned writes of 3 rows (row r, column i = 16*r+i), then rd for 3 cycles -> rows popped in order 0,1,2; o_valid falls after the third pop; a 4th rd leaves pointers unchanged.
- Fill column 0 with 64 entries while other columns stay empty -> o_full=1, o_ready=0, o_valid=0. A 65th write to column 0 is dropped, and with OFIFO_OVERFLOW_FLAG_EN, o_overflow=1 and stays set.
- Fill all columns to 64 entries, then assert rd together with wr=all-ones on the same edge -> writes dropped (full pre-edge), one row popped; next cycle o_full=0 and a write is accepted.
- Streaming 200 rows with rd held high whenever o_valid=1 and a write every cycle -> data crosses the pointer wrap intact; output sequence exactly matches input order with no loss.

Source files
------------

// File: rtl/ofifo.sv
// Output FIFO below the MAC array south edge: per-column queues re-aligned into full rows.
// Latency: a write is visible at the head on the next cycle; reads are show-ahead (zero latency).
// Backpressure: o_ready drops while any column is full; writes to a full column are dropped.
// Build option: define OFIFO_OVERFLOW_FLAG_EN to add the sticky o_overflow output.

// Single column queue with wrap-bit pointers and show-ahead head.
// Latency: write-to-head one cycle, head is combinational from storage.
// Backpressure: wen is ignored while full; ren must only be asserted while non-empty.
module ofifo_col #(
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [psum_bw-1:0] wdat,
  input  logic               wen,
  input  logic               ren,
  output logic [psum_bw-1:0] head,
  output logic               full,
  output logic               empty
);

  localparam int aw = $clog2(depth);

  logic [psum_bw-1:0] mem [depth];
  logic [aw:0]        wr_ptr;
  logic [aw:0]        rd_ptr;
  logic               push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) && (wr_ptr[aw] != rd_ptr[aw]);
  assign push  = wen && !full;
  assign head  = mem[rd_ptr[aw-1:0]];

  // Storage write; reset clears every entry so the head reads 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < depth; k++) mem[k] <= '0;
    end else if (push) begin
      mem[wr_ptr[aw-1:0]] <= wdat;
    end
  end

  // Pointer update; fullness is judged on pre-edge state, so a pop never frees room for a same-edge push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (ren)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// Output FIFO top: one queue per column, popped together as one aligned row.
// Latency: one cycle from write to visibility; out is show-ahead with zero read latency.
// Backpressure: o_ready = ~o_full; rd is ignored until every column holds an entry.
module ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_valid
`ifdef OFIFO_OVERFLOW_FLAG_EN
  ,
  output logic                   o_overflow
`endif
);

  logic [col-1:0] full_c;
  logic [col-1:0] empty_c;
  logic           pop;

  assign o_full  = |full_c;
  assign o_ready = ~o_full;
  assign o_valid = ~|empty_c;
  // A row pops only when every column has data, which keeps the columns aligned.
  assign pop     = rd && o_valid;

  for (genvar g = 0; g < col; g++) begin : g_col
    ofifo_col #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_col (
      .clk   (clk),
      .reset (reset),
      .wdat  (in[psum_bw*g +: psum_bw]),
      .wen   (wr[g]),
      .ren   (pop),
      .head  (out[psum_bw*g +: psum_bw]),
      .full  (full_c[g]),
      .empty (empty_c[g])
    );
  end

`ifdef OFIFO_OVERFLOW_FLAG_EN
  // Sticky record of any write attempted into a full column.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_overflow <= 1'b0;
    end else if (|(wr & full_c)) begin
      o_overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ofifo.sv
// Self-checking bench for ofifo: directed scenarios plus randomized traffic,
// compared every cycle against per-column queue reference model.
module tb_ofifo;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int DEP = 64;

  logic             clk;
  logic             reset;
  logic [127:0]     din;
  logic [7:0]       wr;
  logic             rd;
  logic [127:0]     out;
  logic             o_full;
  logic             o_ready;
  logic             o_valid;
`ifdef OFIFO_OVERFLOW_FLAG_EN
  logic             o_overflow;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one queue per column plus the sticky overflow state.
  logic [15:0] mq [COL][$];
  logic        m_ovf;

  ofifo #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (din),
    .wr      (wr),
    .rd      (rd),
    .out     (out),
    .o_full  (o_full),
    .o_ready (o_ready),
    .o_valid (o_valid)
`ifdef OFIFO_OVERFLOW_FLAG_EN
    ,
    .o_overflow (o_overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_valid();
    logic v = 1'b1;
    for (int i = 0; i < COL; i++) if (mq[i].size() == 0) v = 1'b0;
    return v;
  endfunction

  function automatic logic m_full();
    logic f = 1'b0;
    for (int i = 0; i < COL; i++) if (mq[i].size() == DEP) f = 1'b1;
    return f;
  endfunction

  function automatic logic [127:0] m_row();
    logic [127:0] r = '0;
    for (int i = 0; i < COL; i++) if (mq[i].size() != 0) r[16*i +: 16] = mq[i][0];
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 128'(o_valid), 128'(m_valid()));
    check({tag, ".full"},  128'(o_full),  128'(m_full()));
    check({tag, ".ready"}, 128'(o_ready), 128'(!m_full()));
    if (m_valid()) check({tag, ".out"}, out, m_row());
`ifdef OFIFO_OVERFLOW_FLAG_EN
    check({tag, ".ovf"}, 128'(o_overflow), 128'(m_ovf));
`endif
  endtask

  // Apply one clock of stimulus, advance the model on the edge, then check 1ns later.
  task automatic cycle(input string tag, input logic [7:0] w, input logic [127:0] d, input logic r);
    logic [7:0] fullv;
    logic       vld;
    wr = w; din = d; rd = r;
    @(posedge clk);
    vld = m_valid();
    for (int i = 0; i < COL; i++) fullv[i] = (mq[i].size() == DEP);
    if (r && vld) for (int i = 0; i < COL; i++) void'(mq[i].pop_front());
    for (int i = 0; i < COL; i++) if (w[i] && !fullv[i]) mq[i].push_back(d[16*i +: 16]);
    if (|(w & fullv)) m_ovf = 1'b1;
    #1;
    check_outputs(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges; checks the cleared state before any edge.
  task automatic do_reset(input string tag);
    wr = '0; rd = 1'b0;
    #2 reset = 1'b1;
    #1;
    check({tag, ".rst_valid"}, 128'(o_valid), 128'(0));
    check({tag, ".rst_full"},  128'(o_full),  128'(0));
    check({tag, ".rst_ready"}, 128'(o_ready), 128'(1));
    check({tag, ".rst_out"},   out,           128'(0));
`ifdef OFIFO_OVERFLOW_FLAG_EN
    check({tag, ".rst_ovf"},   128'(o_overflow), 128'(0));
`endif
    for (int i = 0; i < COL; i++) mq[i].delete();
    m_ovf = 1'b0;
    #2 reset = 1'b0;
  endtask

  function automatic logic [127:0] rand_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] d;
    logic [127:0] stair;
    m_ovf = 1'b0;
    reset = 1'b1; wr = '0; rd = 1'b0; din = '0;
    #1;
    check("reset.valid", 128'(o_valid), 128'(0));
    check("reset.full",  128'(o_full),  128'(0));
    check("reset.ready", 128'(o_ready), 128'(1));
    check("reset.out",   out,           128'(0));
    #11 reset = 1'b0;
    for (int c = 0; c < 3; c++) cycle("idle", 8'h00, '0, 1'b1);

    // Staircase skew: column c gets its single entry at cycle c.
    stair = '0;
    for (int i = 0; i < COL; i++) stair[16*i +: 16] = 16'(100 + i);
    for (int c = 0; c < COL; c++) begin
      cycle("stair", 8'(1 << c), stair, 1'b0);
      check("stair.valid_now", 128'(o_valid), 128'(c == COL - 1));
    end
    check("stair.row", out, stair);
    cycle("stair_pop", 8'h00, '0, 1'b1);
    check("stair.drained", 128'(o_valid), 128'(0));

    // Three aligned rows, then four reads (the last one must be ignored).
    for (int r = 0; r < 3; r++) begin
      d = '0;
      for (int i = 0; i < COL; i++) d[16*i +: 16] = 16'(16*r + i);
      cycle("aligned_wr", 8'hff, d, 1'b0);
    end
    for (int r = 0; r < 4; r++) cycle("aligned_rd", 8'h00, '0, 1'b1);
    d = rand_row();
    cycle("aligned_after", 8'hff, d, 1'b0);
    check("aligned.ptr_kept", out, d);
    for (int c = 0; c < 3; c++) cycle("partial", 8'hff, rand_row(), 1'b0);
    do_reset("midfill");

    // Fill column 0 alone past capacity.
    for (int c = 0; c < DEP + 1; c++) cycle("col0_fill", 8'h01, rand_row(), 1'b0);
    check("col0.full", 128'(o_full), 128'(1));
    cycle("col0_more", 8'h01, rand_row(), 1'b0);
    do_reset("col0");

    // Fill everything, then read and write on the same edge.
    for (int c = 0; c < DEP; c++) cycle("all_fill", 8'hff, rand_row(), 1'b0);
    check("all.full", 128'(o_full), 128'(1));
    cycle("all_rdwr", 8'hff, rand_row(), 1'b1);
    check("all.after_pop_full", 128'(o_full), 128'(0));
    cycle("all_wr", 8'hff, rand_row(), 1'b0);
    check("all.refull", 128'(o_full), 128'(1));
    do_reset("all");

    // Streaming across pointer wrap.
    for (int c = 0; c < 200; c++) cycle("stream", 8'hff, rand_row(), m_valid());
    for (int c = 0; c < 4; c++) cycle("stream_drain", 8'h00, '0, 1'b1);

    // Random traffic, biased toward writes so columns fill and skew.
    for (int c = 0; c < 600; c++)
      cycle("random", 8'($urandom), rand_row(), ($urandom_range(0, 2) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
